// File: rtl/eval_unit_arbiter_if.sv
// Signal bundle between requesters, the shared 4-input function unit and the arbiter.
// slave is the arbiter side; master is the requester/unit side.
interface eval_unit_arbiter_if #(
   parameter int N_REQ = 4
) ();
   logic [N_REQ-1:0]   req;
   logic [4*N_REQ-1:0] opnd;
   logic [N_REQ-1:0]   ack;
   logic               result;
   logic               start;
   logic               sweep_done;
   logic [15:0]        tt;
   logic               busy;
   logic               a;
   logic               b;
   logic               c;
   logic               d;
   logic               f;

   modport slave (
      input  req, opnd, start, f,
      output ack, result, sweep_done, tt, busy, a, b, c, d
   );

   modport master (
      output req, opnd, start, f,
      input  ack, result, sweep_done, tt, busy, a, b, c, d
   );
endinterface

// File: rtl/eval_unit_arbiter.sv
// Round-robin arbiter sharing one combinational 4-input Boolean unit among N_REQ
// requesters, plus a 16-code self-sweep that captures the unit's truth table.
module eval_unit_arbiter #(
   parameter int N_REQ = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   eval_unit_arbiter_if.slave bus
);
   localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   typedef enum logic [1:0] {IDLE, EVAL, SWEEP, DONE} state_t;

   state_t           state_reg, state_next;
   logic [3:0]       abcd_reg, abcd_next;
   logic [3:0]       idx_reg, idx_next;
   logic [PW-1:0]    ptr_reg, ptr_next;
   logic [PW-1:0]    win_reg, win_next;
   logic [N_REQ-1:0] ack_reg, ack_next;
   logic             result_reg, result_next;
   logic             done_reg, done_next;
   logic [15:0]      tt_reg, tt_next;

   logic [N_REQ-1:0] eligible;
   logic [3:0]       opnd_arr [N_REQ];
   logic             pick_valid;
   logic [PW-1:0]    pick_id;

   // A requester is masked while its ACK is high so a held REQ is not granted twice.
   genvar gi;
   generate
      for (gi = 0; gi < N_REQ; gi++) begin : g_req
         assign eligible[gi] = bus.req[gi] & ~ack_reg[gi];
         assign opnd_arr[gi] = bus.opnd[4*gi +: 4];
      end
   endgenerate

   always_comb begin
      int            cand;
      logic [PW-1:0] cand_id;
      pick_valid = 1'b0;
      pick_id    = '0;
      cand       = 0;
      cand_id    = '0;
      for (int off = 0; off < N_REQ; off++) begin
         cand = int'(ptr_reg) + off;
         if (cand >= N_REQ) cand = cand - N_REQ;
         cand_id = PW'(cand);
         if (!pick_valid && eligible[cand_id]) begin
            pick_valid = 1'b1;
            pick_id    = cand_id;
         end
      end
   end

   always_comb begin
      state_next  = state_reg;
      abcd_next   = abcd_reg;
      idx_next    = idx_reg;
      ptr_next    = ptr_reg;
      win_next    = win_reg;
      ack_next    = '0;
      result_next = result_reg;
      done_next   = 1'b0;
      tt_next     = tt_reg;
      case (state_reg)
         IDLE: begin
            if (bus.start) begin
               state_next = SWEEP;
               idx_next   = 4'd0;
               abcd_next  = 4'd0;
            end else if (pick_valid) begin
               state_next = EVAL;
               abcd_next  = opnd_arr[pick_id];
               win_next   = pick_id;
            end
         end
         EVAL: begin
            state_next        = IDLE;
            result_next       = bus.f;
            ack_next[win_reg] = 1'b1;
            ptr_next          = (win_reg == PW'(N_REQ - 1)) ? '0 : win_reg + PW'(1);
         end
         SWEEP: begin
            tt_next[idx_reg] = bus.f;
            if (idx_reg != 4'd15) begin
               idx_next  = idx_reg + 4'd1;
               abcd_next = idx_reg + 4'd1;
            end else begin
               state_next = DONE;
               done_next  = 1'b1;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= IDLE;
         abcd_reg   <= '0;
         idx_reg    <= '0;
         ptr_reg    <= '0;
         win_reg    <= '0;
         ack_reg    <= '0;
         result_reg <= 1'b0;
         done_reg   <= 1'b0;
         tt_reg     <= '0;
      end else begin
         state_reg  <= state_next;
         abcd_reg   <= abcd_next;
         idx_reg    <= idx_next;
         ptr_reg    <= ptr_next;
         win_reg    <= win_next;
         ack_reg    <= ack_next;
         result_reg <= result_next;
         done_reg   <= done_next;
         tt_reg     <= tt_next;
      end
   end

   assign bus.a          = abcd_reg[3];
   assign bus.b          = abcd_reg[2];
   assign bus.c          = abcd_reg[1];
   assign bus.d          = abcd_reg[0];
   assign bus.ack        = ack_reg;
   assign bus.result     = result_reg;
   assign bus.sweep_done = done_reg;
   assign bus.tt         = tt_reg;
   assign bus.busy       = (state_reg != IDLE);
endmodule

// File: tb/tb_eval_unit_arbiter.sv
// Directed bench for eval_unit_arbiter with a modelled unit F = ~D | C | B.
module tb_eval_unit_arbiter;
   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;

   eval_unit_arbiter_if #(.N_REQ(4)) bus ();

   eval_unit_arbiter #(.N_REQ(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   assign bus.f = ~bus.d | bus.c | bus.b;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end else begin
         $display("ok   %s: %0h", tag, obs);
      end
   endtask

   // Advance negedge by negedge until any ACK bit is seen or the budget runs out.
   task automatic wait_ack(output int cyc);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (bus.ack == '0 && cyc < 10);
   endtask

   task automatic wait_done(output int cyc, output int acks_seen);
      cyc       = 0;
      acks_seen = 0;
      do begin
         @(negedge clk);
         cyc++;
         if (bus.ack != '0) acks_seen++;
      end while (!bus.sweep_done && cyc < 40);
   endtask

   function automatic logic [3:0] abcd();
      return {bus.a, bus.b, bus.c, bus.d};
   endfunction

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int cyc;
      int acks;
      int rr_id  [5] = '{0, 1, 2, 3, 0};
      int rr_res [5] = '{1, 0, 1, 0, 1};
      logic [3:0] one_hot;

      n_checks  = 0;
      n_errors  = 0;
      rst_n     = 1'b0;
      bus.req   = '0;
      bus.opnd  = '0;
      bus.start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("rst_ack", 32'(bus.ack), 32'h0);
      check("rst_result", 32'(bus.result), 32'h0);
      check("rst_done", 32'(bus.sweep_done), 32'h0);
      check("rst_tt", 32'(bus.tt), 32'h0);
      check("rst_busy", 32'(bus.busy), 32'h0);
      check("rst_abcd", 32'(abcd()), 32'h0);
      rst_n = 1'b1;
      @(negedge clk);

      // Round robin from ptr=0 with all four requesting; operands 0,1,2,9 give F=1,0,1,0.
      bus.opnd = 16'h9210;
      bus.req  = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         wait_ack(cyc);
         one_hot = 4'b0001 << rr_id[k];
         check($sformatf("rr_ack%0d", k), 32'(bus.ack), 32'(one_hot));
         check($sformatf("rr_res%0d", k), 32'(bus.result), 32'(rr_res[k]));
         check($sformatf("rr_gap%0d", k), 32'(cyc), 32'd2);
      end
      bus.req = '0;
      @(negedge clk);
      check("rr_ack_clear", 32'(bus.ack), 32'h0);

      // Single request on requester 2 with operand 0001 -> F=0.
      bus.opnd = 16'h0100;
      bus.req  = 4'b0100;
      @(negedge clk);
      check("sr_busy", 32'(bus.busy), 32'h1);
      check("sr_abcd", 32'(abcd()), 32'h1);
      check("sr_ack_eval", 32'(bus.ack), 32'h0);
      @(negedge clk);
      check("sr_ack", 32'(bus.ack), 32'h4);
      check("sr_result", 32'(bus.result), 32'h0);
      bus.req = '0;
      @(negedge clk);
      check("sr_ack_pulse", 32'(bus.ack), 32'h0);

      // Back-to-back requester 0: operand 0 (F=1) then 9 (F=0).
      bus.opnd = 16'h0000;
      bus.req  = 4'b0001;
      wait_ack(cyc);
      check("bb_ack0", 32'(bus.ack), 32'h1);
      check("bb_res0", 32'(bus.result), 32'h1);
      bus.opnd = 16'h0009;
      wait_ack(cyc);
      check("bb_ack1", 32'(bus.ack), 32'h1);
      check("bb_res1", 32'(bus.result), 32'h0);
      bus.req = '0;
      @(negedge clk);

      // Full sweep: done 17 cycles after START is sampled, TT = FDFD.
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      wait_done(cyc, acks);
      check("sw_latency", 32'(cyc + 1), 32'd17);
      check("sw_done", 32'(bus.sweep_done), 32'h1);
      check("sw_tt", 32'(bus.tt), 32'hFDFD);
      check("sw_busy_done", 32'(bus.busy), 32'h1);
      @(negedge clk);
      check("sw_done_pulse", 32'(bus.sweep_done), 32'h0);
      check("sw_idle", 32'(bus.busy), 32'h0);

      // START and REQ[1] together: sweep first, then the grant (operand 4 -> F=1).
      bus.opnd  = 16'h0040;
      bus.req   = 4'b0010;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      wait_done(cyc, acks);
      check("col_done", 32'(bus.sweep_done), 32'h1);
      check("col_no_early_ack", 32'(acks), 32'h0);
      check("col_tt", 32'(bus.tt), 32'hFDFD);
      wait_ack(cyc);
      check("col_ack", 32'(bus.ack), 32'h2);
      check("col_result", 32'(bus.result), 32'h1);
      bus.req = '0;
      @(negedge clk);

      // Asynchronous reset mid-sweep at idx=7, then no SWEEP_DONE afterwards.
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      cyc = 0;
      while (abcd() != 4'd7 && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      check("ar_reach_idx7", 32'(abcd()), 32'h7);
      #2 rst_n = 1'b0;
      #1;
      check("ar_abcd", 32'(abcd()), 32'h0);
      check("ar_busy", 32'(bus.busy), 32'h0);
      check("ar_tt", 32'(bus.tt), 32'h0);
      check("ar_result", 32'(bus.result), 32'h0);
      check("ar_ack_done", 32'({bus.ack, bus.sweep_done}), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      acks = 0;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (bus.sweep_done) acks++;
      end
      check("ar_no_done", 32'(acks), 32'h0);
      check("ar_idle", 32'(bus.busy), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
